// File: rtl/core_pkg.sv
// Shared definitions for the multi-cycle RISC-V sequencer: FSM state
// encodings, the supported opcodes, ALU control codes and the decode
// helper that maps an opcode onto its registered datapath controls.
package core_pkg;

    // FSM states; the numeric values are visible on the state output.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_e;

    // Supported major opcodes (instruction[6:0]).
    localparam logic [6:0] OPC_RTYPE  = 7'h33;
    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_BRANCH = 7'h63;

    // ALU control codes understood by the existing ALU control block.
    localparam logic [3:0] ALUOP_LDST   = 4'd0;
    localparam logic [3:0] ALUOP_RTYPE  = 4'd2;
    localparam logic [3:0] ALUOP_BRANCH = 4'd7;

    // Instruction class remembered after DECODE to steer EXEC and MEM.
    typedef enum logic [1:0] {
        CLS_R  = 2'd0,
        CLS_LD = 2'd1,
        CLS_ST = 2'd2,
        CLS_BR = 2'd3
    } op_class_e;

    // Datapath controls latched in DECODE and held until the next DECODE.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src;
        logic       mem_to_rgs;
        logic       brnch;
    } dec_ctrl_t;

    // True for the four opcodes this sequencer can execute.
    function automatic logic is_legal(input logic [6:0] opc);
        return (opc == OPC_RTYPE) || (opc == OPC_LOAD) ||
               (opc == OPC_STORE) || (opc == OPC_BRANCH);
    endfunction

    // Class of a legal opcode; callers only use it after is_legal().
    function automatic op_class_e op_class(input logic [6:0] opc);
        op_class_e cls;
        case (opc)
            OPC_LOAD:   cls = CLS_LD;
            OPC_STORE:  cls = CLS_ST;
            OPC_BRANCH: cls = CLS_BR;
            default:    cls = CLS_R;
        endcase
        return cls;
    endfunction

    // Datapath controls for a legal opcode.
    function automatic dec_ctrl_t decode_ctrl(input logic [6:0] opc);
        dec_ctrl_t c;
        c = '0;
        case (opc)
            OPC_RTYPE: begin
                c.alu_op  = ALUOP_RTYPE;
                c.alu_src = 1'b0;
            end
            OPC_LOAD: begin
                c.alu_op     = ALUOP_LDST;
                c.alu_src    = 1'b1;
                c.mem_to_rgs = 1'b1;
            end
            OPC_STORE: begin
                c.alu_op  = ALUOP_LDST;
                c.alu_src = 1'b1;
            end
            OPC_BRANCH: begin
                c.alu_op  = ALUOP_BRANCH;
                c.alu_src = 1'b0;
                c.brnch   = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/core_seq_ctrl_if.sv
// Request/acknowledge handshakes between the sequencer and the
// instruction and data memories. The sequencer is the master.
interface core_seq_ctrl_if;

    logic imem_req;
    logic imem_ack;
    logic dmem_req;
    logic dmem_ack;

    modport master (
        output imem_req,
        output dmem_req,
        input  imem_ack,
        input  dmem_ack
    );

    modport slave (
        input  imem_req,
        input  dmem_req,
        output imem_ack,
        output dmem_ack
    );

endinterface

// File: rtl/perf_counters.sv
// Busy-cycle and retired-instruction counters. Both wrap freely.
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cycle_en,
    input  logic             retire_en,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret
);

    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] cycle_d;
    logic [CNT_W-1:0] instret_q;
    logic [CNT_W-1:0] instret_d;

    // Next-count values: add one when the matching enable is high.
    always_comb begin
        cycle_d   = cycle_q   + {{(CNT_W-1){1'b0}}, cycle_en};
        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire_en};
    end

    // Counter registers, cleared by the asynchronous reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt = cycle_q;
    assign instret   = instret_q;

endmodule

// File: rtl/core_seq_ctrl.sv
// Multi-cycle sequencer: walks each instruction through FETCH, DECODE,
// EXEC, MEM and WB, handshakes with both memories, drives the datapath
// strobes and stops in HALT on a halt request or an unsupported opcode.
module core_seq_ctrl
    import core_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  run,
    input  logic                  halt_req,
    input  logic [6:0]            opcode,
    input  logic                  zero,
    core_seq_ctrl_if.master       mem_bus,
    output logic                  ir_we,
    output logic                  pc_we,
    output logic                  pc_sel,
    output logic                  reg_wr,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic                  mem_to_rgs,
    output logic                  alu_src,
    output logic                  brnch,
    output logic [3:0]            alu_op,
    output logic [2:0]            state,
    output logic                  busy,
    output logic                  illegal,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      instret
);

    state_e    state_q;
    state_e    state_d;
    op_class_e op_q;
    dec_ctrl_t ctrl_q;
    logic      illegal_q;
    logic      imem_req_q;
    logic      dmem_req_q;
    logic      mem_rd_q;
    logic      mem_wr_q;

    logic      retire_c;
    logic      ir_we_c;
    logic      pc_we_c;
    logic      pc_sel_c;
    logic      reg_wr_c;
    logic      opc_ok;

    assign opc_ok = is_legal(opcode);

    // Next state plus the single-cycle strobes that accompany each transition.
    always_comb begin
        state_d  = state_q;
        retire_c = 1'b0;
        ir_we_c  = 1'b0;
        pc_we_c  = 1'b0;
        pc_sel_c = 1'b0;
        reg_wr_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_bus.imem_ack) begin
                    ir_we_c = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                state_d = opc_ok ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                case (op_q)
                    CLS_BR: begin
                        retire_c = 1'b1;
                        pc_sel_c = zero;
                    end
                    CLS_R:   state_d = S_WB;
                    default: state_d = S_MEM;
                endcase
            end
            S_MEM: begin
                if (mem_bus.dmem_ack) begin
                    if (op_q == CLS_ST) begin
                        retire_c = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                reg_wr_c = 1'b1;
                retire_c = 1'b1;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Every retirement updates the PC and picks the next instruction
        // boundary; a halt request outranks run.
        if (retire_c) begin
            pc_we_c = 1'b1;
            if (halt_req) begin
                state_d = S_HALT;
            end else if (run) begin
                state_d = S_FETCH;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    // FSM state, registered memory requests and the decoded controls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            op_q       <= CLS_R;
            ctrl_q     <= '0;
            illegal_q  <= 1'b0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            // Requests stay up from the first cycle of the access state
            // through the ack cycle, because they track the entered state.
            imem_req_q <= (state_d == S_FETCH);
            dmem_req_q <= (state_d == S_MEM);
            mem_rd_q   <= (state_d == S_MEM) && (op_q == CLS_LD);
            mem_wr_q   <= (state_d == S_MEM) && (op_q == CLS_ST);
            if (state_q == S_DECODE) begin
                if (opc_ok) begin
                    op_q   <= op_class(opcode);
                    ctrl_q <= decode_ctrl(opcode);
                end else begin
                    // Controls keep their last legal values; only the
                    // sticky flag records the bad opcode.
                    illegal_q <= 1'b1;
                end
            end
        end
    end

    perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk       (clk),
        .reset     (reset),
        .cycle_en  (busy),
        .retire_en (retire_c),
        .cycle_cnt (cycle_cnt),
        .instret   (instret)
    );

    assign mem_bus.imem_req = imem_req_q;
    assign mem_bus.dmem_req = dmem_req_q;

    assign ir_we      = ir_we_c;
    assign pc_we      = pc_we_c;
    assign pc_sel     = pc_sel_c;
    assign reg_wr     = reg_wr_c;
    assign mem_rd     = mem_rd_q;
    assign mem_wr     = mem_wr_q;
    assign mem_to_rgs = ctrl_q.mem_to_rgs;
    assign alu_src    = ctrl_q.alu_src;
    assign brnch      = ctrl_q.brnch;
    assign alu_op     = ctrl_q.alu_op;
    assign state      = state_q;
    assign busy       = (state_q != S_IDLE) && (state_q != S_HALT);
    assign illegal    = illegal_q;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl. Each instruction is expanded into
// its expected cycle-by-cycle trace from its class and wait counts; a
// single negedge process compares the DUT against that trace.
module tb_core_seq_ctrl;

    localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                           ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_HALT = 3'd6;

    logic        clk;
    logic        reset;
    logic        run;
    logic        halt_req;
    logic [6:0]  opcode;
    logic        zero;
    logic        ir_we, pc_we, pc_sel, reg_wr, mem_rd, mem_wr;
    logic        mem_to_rgs, alu_src, brnch, busy, illegal;
    logic [3:0]  alu_op;
    logic [2:0]  state;
    logic [31:0] cycle_cnt, instret;

    core_seq_ctrl_if bus();

    core_seq_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .run        (run),
        .halt_req   (halt_req),
        .opcode     (opcode),
        .zero       (zero),
        .mem_bus    (bus),
        .ir_we      (ir_we),
        .pc_we      (pc_we),
        .pc_sel     (pc_sel),
        .reg_wr     (reg_wr),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_to_rgs (mem_to_rgs),
        .alu_src    (alu_src),
        .brnch      (brnch),
        .alu_op     (alu_op),
        .state      (state),
        .busy       (busy),
        .illegal    (illegal),
        .cycle_cnt  (cycle_cnt),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: counters, sticky flag and the latched decode controls.
    logic [31:0] m_cyc, m_ret;
    logic        m_ill, m_alusrc, m_m2r, m_br;
    logic [3:0]  m_aluop;

    // Inputs to apply on the next cycle.
    logic        drv_run, drv_halt, drv_zero;
    logic [6:0]  drv_op;

    // Expected outputs for the current cycle.
    logic        exp_valid;
    logic [2:0]  e_state;
    logic        e_ireq, e_dreq, e_irwe, e_pcwe, e_pcsel, e_regwr, e_mrd, e_mwr, e_busy;
    logic        e_ill, e_alusrc, e_m2r, e_br;
    logic [3:0]  e_aluop;
    logic [31:0] e_cyc, e_ret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // The one compare process: DUT versus the expected trace entry.
    always @(negedge clk) begin
        if (exp_valid) begin
            chk("state",      64'(state),        64'(e_state));
            chk("imem_req",   64'(bus.imem_req), 64'(e_ireq));
            chk("dmem_req",   64'(bus.dmem_req), 64'(e_dreq));
            chk("ir_we",      64'(ir_we),        64'(e_irwe));
            chk("pc_we",      64'(pc_we),        64'(e_pcwe));
            chk("pc_sel",     64'(pc_sel),       64'(e_pcsel));
            chk("reg_wr",     64'(reg_wr),       64'(e_regwr));
            chk("mem_rd",     64'(mem_rd),       64'(e_mrd));
            chk("mem_wr",     64'(mem_wr),       64'(e_mwr));
            chk("busy",       64'(busy),         64'(e_busy));
            chk("illegal",    64'(illegal),      64'(e_ill));
            chk("alu_op",     64'(alu_op),       64'(e_aluop));
            chk("alu_src",    64'(alu_src),      64'(e_alusrc));
            chk("mem_to_rgs", 64'(mem_to_rgs),   64'(e_m2r));
            chk("brnch",      64'(brnch),        64'(e_br));
            chk("cycle_cnt",  64'(cycle_cnt),    64'(e_cyc));
            chk("instret",    64'(instret),      64'(e_ret));
        end
    end

    // One clock cycle: apply inputs, publish expectations, then advance
    // the model counters once the compare has run.
    task automatic step(input logic [2:0] st, input logic ireq, input logic dreq,
                        input logic irwe, input logic pcwe, input logic pcsel,
                        input logic regwr, input logic mrd, input logic mwr,
                        input logic ia, input logic da);
        @(posedge clk);
        #1;
        bus.imem_ack = ia;
        bus.dmem_ack = da;
        run      = drv_run;
        halt_req = drv_halt;
        zero     = drv_zero;
        opcode   = drv_op;
        e_state  = st;
        e_ireq   = ireq;
        e_dreq   = dreq;
        e_irwe   = irwe;
        e_pcwe   = pcwe;
        e_pcsel  = pcsel;
        e_regwr  = regwr;
        e_mrd    = mrd;
        e_mwr    = mwr;
        e_busy   = (st != ST_IDLE) && (st != ST_HALT);
        e_ill    = m_ill;
        e_aluop  = m_aluop;
        e_alusrc = m_alusrc;
        e_m2r    = m_m2r;
        e_br     = m_br;
        e_cyc    = m_cyc;
        e_ret    = m_ret;
        exp_valid = 1'b1;
        @(negedge clk);
        #1;
        if (e_busy) m_cyc = m_cyc + 32'd1;
        if (pcwe)   m_ret = m_ret + 32'd1;
    endtask

    // Controls each supported opcode must present after DECODE.
    task automatic model_decode(input logic [6:0] op);
        case (op)
            7'h33:   begin m_aluop = 4'd2; m_alusrc = 1'b0; m_m2r = 1'b0; m_br = 1'b0; end
            7'h03:   begin m_aluop = 4'd0; m_alusrc = 1'b1; m_m2r = 1'b1; m_br = 1'b0; end
            7'h23:   begin m_aluop = 4'd0; m_alusrc = 1'b1; m_m2r = 1'b0; m_br = 1'b0; end
            default: begin m_aluop = 4'd7; m_alusrc = 1'b0; m_m2r = 1'b0; m_br = 1'b1; end
        endcase
    endtask

    // Asynchronous reset mid-cycle; every output must drop at once.
    task automatic do_reset(input logic run_v);
        @(posedge clk);
        #3;
        exp_valid = 1'b0;
        reset = 1'b0;
        bus.imem_ack = 1'b0;
        bus.dmem_ack = 1'b1;
        #1;
        chk("rst_state",   64'(state),        64'd0);
        chk("rst_imem",    64'(bus.imem_req), 64'd0);
        chk("rst_dmem",    64'(bus.dmem_req), 64'd0);
        chk("rst_strobes", 64'({ir_we, pc_we, pc_sel, reg_wr, mem_rd, mem_wr}), 64'd0);
        chk("rst_ctrl",    64'({alu_op, alu_src, mem_to_rgs, brnch}), 64'd0);
        chk("rst_flags",   64'({busy, illegal}), 64'd0);
        chk("rst_cycle",   64'(cycle_cnt),    64'd0);
        chk("rst_instret", 64'(instret),      64'd0);
        m_cyc = '0; m_ret = '0; m_ill = 1'b0;
        m_aluop = '0; m_alusrc = 1'b0; m_m2r = 1'b0; m_br = 1'b0;
        run = run_v; drv_run = run_v; halt_req = 1'b0; drv_halt = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Expand one instruction into its expected trace. iw/dw are ack wait
    // cycles; noise drives halt_req high, run low and stray acks in cycles
    // where they must be ignored.
    task automatic do_instr(input logic [6:0] op, input int iw, input int dw,
                            input logic z, input logic h, input logic r_after,
                            input logic noise);
        logic is_r, is_ld, is_st, is_br;
        is_r  = (op == 7'h33);
        is_ld = (op == 7'h03);
        is_st = (op == 7'h23);
        is_br = (op == 7'h63);
        drv_op = op; drv_zero = z; drv_run = !noise; drv_halt = noise;
        for (int k = 0; k <= iw; k++)
            step(ST_FETCH, 1, 0, (k == iw), 0, 0, 0, 0, 0, (k == iw), (k != iw));
        step(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, noise, noise);
        if (!(is_r || is_ld || is_st || is_br)) begin
            m_ill = 1'b1;
            $display("instr op=%02h illegal -> halt, instret=%0d", op, m_ret);
            return;
        end
        model_decode(op);
        if (is_br) begin
            drv_halt = h; drv_run = r_after;
            step(ST_EXEC, 0, 0, 0, 1, z, 0, 0, 0, noise, noise);
        end else begin
            step(ST_EXEC, 0, 0, 0, 0, 0, 0, 0, 0, noise, noise);
            if (is_ld || is_st) begin
                for (int k = 0; k <= dw; k++) begin
                    if (is_st && k == dw) begin drv_halt = h; drv_run = r_after; end
                    step(ST_MEM, 0, 1, 0, (is_st && k == dw), 0, 0, is_ld, is_st,
                         (k != dw) && noise, (k == dw));
                end
            end
            if (is_r || is_ld) begin
                drv_halt = h; drv_run = r_after;
                step(ST_WB, 0, 0, 0, 1, 0, 1, 0, 0, noise, noise);
            end
        end
        $display("instr op=%02h iw=%0d dw=%0d zero=%0d retired, instret=%0d cycles=%0d",
                 op, iw, dw, z, m_ret, m_cyc);
    endtask

    task automatic halt_steps(input int n);
        drv_run = 1'b1;
        for (int k = 0; k < n; k++)
            step(ST_HALT, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; halt_req = 1'b0; opcode = '0; zero = 1'b0;
        bus.imem_ack = 1'b0; bus.dmem_ack = 1'b0;
        exp_valid = 1'b0;
        drv_run = 1'b0; drv_halt = 1'b0; drv_zero = 1'b0; drv_op = '0;

        do_reset(1'b0);
        step(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        drv_run = 1'b1;
        step(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // R-type, zero-wait: 4 cycles, one retirement.
        do_instr(7'h33, 0, 0, 0, 0, 1, 0);
        chk("rt_regwr_lit", 64'(reg_wr), 64'd1);
        chk("rt_pin_cyc",   64'(m_cyc),  64'd4);
        chk("rt_pin_ret",   64'(m_ret),  64'd1);

        // Load with data ack three cycles late: 8 cycles.
        do_instr(7'h03, 0, 3, 0, 0, 1, 0);
        chk("ld_m2r_lit",   64'(mem_to_rgs), 64'd1);
        chk("ld_pin_cyc",   64'(m_cyc),  64'd12);
        chk("ld_pin_ret",   64'(m_ret),  64'd2);

        // Branch taken after a slow fetch, with halt_req/run noise mid-flight.
        do_instr(7'h63, 2, 0, 1, 0, 1, 1);
        chk("br1_pcsel_lit", 64'({pc_we, pc_sel}), 64'd3);
        chk("br1_pin_cyc",  64'(m_cyc),  64'd17);

        // Branch not taken; run low at retirement returns to IDLE.
        do_instr(7'h63, 0, 0, 0, 0, 0, 0);
        chk("br0_pcsel_lit", 64'({pc_we, pc_sel}), 64'd2);
        chk("br0_pin_ret",  64'(m_ret),  64'd4);

        drv_run = 1'b0;
        step(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        step(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        drv_run = 1'b1;
        step(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // Store, zero-wait: 4 cycles.
        do_instr(7'h23, 0, 0, 0, 0, 1, 0);
        chk("st_pin_cyc",   64'(m_cyc),  64'd24);

        // Store with halt_req at retirement: retires, then HALT for good.
        do_instr(7'h23, 0, 1, 0, 1, 1, 0);
        halt_steps(3);
        chk("sth_state_lit", 64'(state),  64'd6);
        chk("sth_ret_lit",   64'(instret), 64'd6);
        chk("sth_pin_cyc",   64'(m_cyc),  64'd29);

        // Illegal opcode: HALT after DECODE, nothing retires.
        do_reset(1'b1);
        do_instr(7'h7F, 0, 0, 0, 0, 1, 1);
        halt_steps(3);
        chk("ill_flag_lit", 64'(illegal), 64'd1);
        chk("ill_ret_lit",  64'(instret), 64'd0);
        chk("ill_pin_cyc",  64'(m_cyc),   64'd2);

        // Reset while a load waits in MEM, then restart immediately.
        do_reset(1'b1);
        drv_op = 7'h03; drv_run = 1'b1; drv_halt = 1'b0; drv_zero = 1'b0;
        step(ST_FETCH,  1, 0, 1, 0, 0, 0, 0, 0, 1, 0);
        step(ST_DECODE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        model_decode(7'h03);
        step(ST_EXEC,   0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step(ST_MEM,    0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(ST_MEM,    0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
        #3;
        chk("pre_rst_dmem", 64'({bus.dmem_req, mem_rd}), 64'd3);
        do_reset(1'b1);
        do_instr(7'h33, 0, 0, 0, 0, 0, 0);
        drv_run = 1'b0;
        step(ST_IDLE, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("post_rst_ret", 64'(instret), 64'd1);
        chk("post_rst_cyc", 64'(cycle_cnt), 64'd4);

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/core_seq_ctrl.md
# core_seq_ctrl

Multi-cycle sequencer for the single-issue RISC-V datapath, which includes the exact/approximate ALU, register file, and instruction and data memories. It replaces the free-running `step` toggle with an FSM. Each instruction moves through FETCH, DECODE, EXEC, MEM and WB. In each state the FSM drives the datapath strobes and handshakes with both memories. It also keeps cycle and retired-instruction counters and stops cleanly on halt requests or illegal opcodes.

## Interface
- `CNT_W`, default 32: width of `cycle_cnt` and `instret`.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low reset.
- `run` input, 1 bit: level; while high, allows leaving IDLE and continuing at instruction boundaries.
- `halt_req` input, 1 bit: level, sampled only at retirement.
- `opcode` input, 7 bits: `instruction[6:0]`, valid from DECODE onward.
- `zero` input, 1 bit: ALU result == 0, valid in EXEC.
- `imem_ack` input, 1 bit: instruction word valid; accepted in FETCH.
- `dmem_ack` input, 1 bit: data access done; accepted in MEM.
- `imem_req` output, 1 bit: held high in FETCH until ack.
- `dmem_req` output, 1 bit: held high in MEM until ack.
- `ir_we` output, 1 bit: instruction register load.
- `pc_we` output, 1 bit: PC update.
- `pc_sel` output, 1 bit: 1 = jump address, 0 = PC + 1.
- `reg_wr`, `mem_rd`, `mem_wr`, `mem_to_rgs`, `alu_src`, `brnch` outputs, 1 bit each: datapath controls.
- `alu_op` output, 4 bits: 2 = R-type, 0 = load/store, 7 = branch.
- `state` output, 3 bits: current FSM state.
- `busy` output, 1 bit: state is not IDLE and not HALT.
- `illegal` output, 1 bit: sticky; set on unsupported opcode.
- `cycle_cnt` output, `CNT_W` bits: count of busy cycles.
- `instret` output, `CNT_W` bits: count of retired instructions.

## Operation
- State encoding: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
- Reset (asynchronous, `reset`=0):
  - state goes to IDLE.
  - All outputs are 0, including counters and `illegal`.
  - Reset wins over any in-progress access. Outstanding acks are ignored after release.
- IDLE: go to FETCH when `run`=1.
- FETCH:
  - `imem_req`=1 while waiting.
  - On `imem_ack`: `ir_we`=1 for that cycle, then go to DECODE.
- DECODE:
  - Opcode 0x33: `alu_op`=2, `alu_src`=0.
  - Opcode 0x03: `alu_op`=0, `alu_src`=1, `mem_to_rgs`=1.
  - Opcode 0x23: `alu_op`=0, `alu_src`=1.
  - Opcode 0x63: `alu_op`=7, `alu_src`=0, `brnch`=1.
  - These are registered and held until the next DECODE.
  - Any other opcode: set `illegal`, go to HALT, do not retire.
- EXEC:
  - 0x33 goes to WB; 0x03 and 0x23 go to MEM.
  - 0x63 retires here: `pc_we`=1 and `pc_sel`=`zero`.
- MEM:
  - `dmem_req`=1, with `mem_rd`=1 for a load or `mem_wr`=1 for a store, held until `dmem_ack`.
  - Store: retires on the ack with `pc_we`=1 and `pc_sel`=0.
  - Load: goes to WB on the ack.
- WB: `reg_wr`=1 and `pc_we`=1 with `pc_sel`=0, then retire.
- Retirement cycle:
  - `instret` increments by 1.
  - Next state is HALT if `halt_req`=1, else FETCH if `run`=1, else IDLE.
  - `halt_req` takes priority over `run`.
- HALT is terminal: only reset exits it, and all strobes are 0.
- `cycle_cnt` increments every cycle in which `busy`=1.
- Both counters wrap modulo 2^`CNT_W` with no saturation.

## Timing
- `reg_wr`, `pc_we`, `ir_we` and `pc_sel` are single-cycle strobes. They are asserted combinationally from state and inputs in the same cycle as the transition they accompany.
- `imem_req` and `dmem_req` are registered-state outputs. They are high from the first cycle of FETCH or MEM through the ack cycle inclusive.
- An ack arriving in any other state is ignored.
- Latency with zero-wait acks (ack in the first cycle):
  - Branch: 3 cycles.
  - R-type: 4 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each wait cycle adds 1.
- `run` falling mid-instruction has no effect until retirement.
- `illegal` is set on the cycle leaving DECODE and is visible the next cycle with state=HALT.

## Structure
- Shared package `core_pkg` holds:
  - state encodings;
  - opcode constants: RTYPE 0x33, LOAD 0x03, STORE 0x23, BRANCH 0x63;
  - `alu_op` encodings 0, 2 and 7, matching the existing ALU control.
- One natural sub-module, `perf_counters`: the `cycle_cnt` and `instret` registers with their increment enables.
- The FSM and strobe decode stay in `core_seq_ctrl`.

## Test plan
- R-type (0x33), `run`=1, acks immediate:
  - states 1→2→3→5→1;
  - `reg_wr` and `pc_we` high in cycle 4 only, `pc_sel`=0;
  - `instret`=1, `cycle_cnt`=4.
- Load (0x03) with `dmem_ack` 3 cycles late:
  - `dmem_req` and `mem_rd` high 4 cycles;
  - WB follows, total 8 cycles;
  - `mem_to_rgs`=1 through WB.
- Branch (0x63):
  - with `zero`=1: `pc_we`=1 and `pc_sel`=1 in cycle 3;
  - repeated with `zero`=0: `pc_sel`=0;
  - `reg_wr` never asserts.
- Opcode 0x7F: HALT after DECODE, `illegal`=1, `instret` unchanged. Subsequent `run` and acks are ignored.
- `halt_req`=1 during store MEM with `dmem_ack`: retires, state=HALT, `instret`+1.
- Reset asserted in MEM with `dmem_req` high:
  - immediately state=IDLE and all outputs 0;
  - after release with `run`=1, FETCH starts next cycle.
